// File: rtl/led_mode_controller.sv
// Push-switch driven LED sequencer: synchronize and debounce the switch, then step
// OFF -> ON -> BLINK -> CHASE on every debounced release.
module led_mode_controller #(
  parameter int unsigned DEBOUNCE_LIMIT = 250000,
  parameter int unsigned SLOW_DIV       = 12500000,
  parameter int unsigned FAST_DIV       = 3125000
) (
  input  logic       i_Clk,
  input  logic       i_Rst_n,
  input  logic       i_Switch,
  output logic [1:0] o_Mode,
  output logic       o_Release,
  output logic [3:0] o_Led
);

  localparam int unsigned DebW   = (DEBOUNCE_LIMIT > 1) ? $clog2(DEBOUNCE_LIMIT) : 1;
  localparam int unsigned MaxDiv = (SLOW_DIV > FAST_DIV) ? SLOW_DIV : FAST_DIV;
  localparam int unsigned TickW  = (MaxDiv > 1) ? $clog2(MaxDiv) : 1;

  localparam logic [DebW-1:0]  DebLast  = DebW'(DEBOUNCE_LIMIT - 1);
  localparam logic [TickW-1:0] SlowLast = TickW'(SLOW_DIV - 1);
  localparam logic [TickW-1:0] FastLast = TickW'(FAST_DIV - 1);

  typedef enum logic [1:0] {
    StOff   = 2'd0,
    StOn    = 2'd1,
    StBlink = 2'd2,
    StChase = 2'd3
  } mode_e;

  logic            sync1_q, sw_sync;
  logic            deb_q, deb_d, deb_prev_q;
  logic [DebW-1:0] deb_cnt_q, deb_cnt_d;
  logic            release_q, release_d;

  mode_e            mode_q, mode_d;
  logic [3:0]       led_q, led_d;
  logic [TickW-1:0] tick_q, tick_d;

  // Debounce: any disagreement that survives DEBOUNCE_LIMIT cycles is accepted.
  always_comb begin
    deb_d     = deb_q;
    deb_cnt_d = '0;
    if (sw_sync != deb_q) begin
      if (deb_cnt_q == DebLast) begin
        deb_d = sw_sync;
      end else begin
        deb_cnt_d = deb_cnt_q + 1'b1;
      end
    end
    release_d = deb_prev_q & ~deb_q;
  end

  // Mode FSM and pattern generator; tick_d defaults to 0 so mode changes and wraps clear it.
  always_comb begin
    mode_d = mode_q;
    led_d  = led_q;
    tick_d = '0;
    if (release_q) begin
      unique case (mode_q)
        StOff:   begin mode_d = StOn;    led_d = 4'b1111; end
        StOn:    begin mode_d = StBlink; led_d = 4'b1111; end
        StBlink: begin mode_d = StChase; led_d = 4'b0001; end
        StChase: begin mode_d = StOff;   led_d = 4'b0000; end
        default: begin mode_d = StOff;   led_d = 4'b0000; end
      endcase
    end else begin
      unique case (mode_q)
        StOff: led_d = 4'b0000;
        StOn:  led_d = 4'b1111;
        StBlink: begin
          if (tick_q == SlowLast) led_d = ~led_q;
          else                    tick_d = tick_q + 1'b1;
        end
        StChase: begin
          if (tick_q == FastLast) led_d = {led_q[2:0], led_q[3]};
          else                    tick_d = tick_q + 1'b1;
        end
        default: led_d = 4'b0000;
      endcase
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      sync1_q    <= 1'b0;
      sw_sync    <= 1'b0;
      deb_q      <= 1'b0;
      deb_prev_q <= 1'b0;
      deb_cnt_q  <= '0;
      release_q  <= 1'b0;
      mode_q     <= StOff;
      led_q      <= 4'b0000;
      tick_q     <= '0;
    end else begin
      sync1_q    <= i_Switch;
      sw_sync    <= sync1_q;
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      deb_cnt_q  <= deb_cnt_d;
      release_q  <= release_d;
      mode_q     <= mode_d;
      led_q      <= led_d;
      tick_q     <= tick_d;
    end
  end

  assign o_Mode    = mode_q;
  assign o_Release = release_q;
  assign o_Led     = led_q;

endmodule

// File: tb/tb_led_mode_controller.sv
// Directed bench for led_mode_controller with DEBOUNCE_LIMIT=4, SLOW_DIV=8, FAST_DIV=4.
module tb_led_mode_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sw;
  logic [1:0] mode;
  logic       rel;
  logic [3:0] led;

  int vectors    = 0;
  int miscompares = 0;

  led_mode_controller #(
    .DEBOUNCE_LIMIT(4),
    .SLOW_DIV      (8),
    .FAST_DIV      (4)
  ) dut (
    .i_Clk    (clk),
    .i_Rst_n  (rst_n),
    .i_Switch (sw),
    .o_Mode   (mode),
    .o_Release(rel),
    .o_Led    (led)
  );

  always #5 clk = ~clk;

  // Advance n rising edges, then sample 1 time unit later.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [1:0] m, input logic r,
                           input logic [3:0] l);
    check({tag, "_mode"}, {2'b00, mode}, {2'b00, m});
    check({tag, "_rel"}, {3'b000, rel}, {3'b000, r});
    check({tag, "_led"}, led, l);
  endtask

  // Clean press then release; returns sampled just after the mode-change edge.
  task automatic do_release(input string tag, input logic [1:0] new_mode,
                            input logic [3:0] entry_led);
    sw = 1'b1;
    step(10);
    sw = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      step(1);
      check({tag, "_norel"}, {3'b000, rel}, 4'h0);
    end
    step(1);
    check({tag, "_rel7"}, {3'b000, rel}, 4'h1);
    step(1);
    check_all({tag, "_entry"}, new_mode, 1'b0, entry_led);
  endtask

  initial begin
    rst_n = 1'b0;
    sw    = 1'b0;

    // 1. Reset held with a toggling switch, then released.
    for (int i = 0; i < 8; i++) begin
      sw = i[0];
      step(1);
      check_all("rst_hold", 2'd0, 1'b0, 4'b0000);
    end
    sw    = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step(1);
      check_all("rst_after", 2'd0, 1'b0, 4'b0000);
    end

    // 3. Bounce rejection: 2 high / 1 low, ten times.
    for (int i = 0; i < 10; i++) begin
      sw = 1'b1;
      step(1);
      check_all("bounce_h1", 2'd0, 1'b0, 4'b0000);
      step(1);
      check_all("bounce_h2", 2'd0, 1'b0, 4'b0000);
      sw = 1'b0;
      step(1);
      check_all("bounce_l", 2'd0, 1'b0, 4'b0000);
    end
    for (int i = 0; i < 10; i++) begin
      step(1);
      check_all("bounce_settle", 2'd0, 1'b0, 4'b0000);
    end

    // 2. Clean press of 20 cycles then release.
    sw = 1'b1;
    step(20);
    check_all("press_held", 2'd0, 1'b0, 4'b0000);
    sw = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      step(1);
      check("clean_norel", {3'b000, rel}, 4'h0);
    end
    step(1);
    check_all("clean_rel7", 2'd0, 1'b1, 4'b0000);
    step(1);
    check_all("clean_on", 2'd1, 1'b0, 4'b1111);
    step(1);
    check_all("clean_single", 2'd1, 1'b0, 4'b1111);

    // Holding pressed in ON: no mode change.
    sw = 1'b1;
    step(30);
    check_all("hold_on", 2'd1, 1'b0, 4'b1111);
    sw = 1'b0;
    step(7);
    check("hold_rel", {3'b000, rel}, 4'h1);
    step(1);
    check_all("hold_to_blink", 2'd2, 1'b0, 4'b1111);

    // 4. BLINK timing from the mode-change edge.
    step(7);
    check("blink_7", led, 4'b1111);
    step(1);
    check("blink_8", led, 4'b0000);
    step(7);
    check("blink_15", led, 4'b0000);
    step(1);
    check("blink_16", led, 4'b1111);

    // 5. CHASE rotation and wrap to OFF.
    do_release("to_chase", 2'd3, 4'b0001);
    step(3);
    check("chase_3", led, 4'b0001);
    step(1);
    check("chase_4", led, 4'b0010);
    step(4);
    check("chase_8", led, 4'b0100);
    step(4);
    check("chase_12", led, 4'b1000);
    step(4);
    check("chase_16", led, 4'b0001);
    do_release("wrap", 2'd0, 4'b0000);
    step(5);
    check_all("off_stable", 2'd0, 1'b0, 4'b0000);

    // 6. Asynchronous reset mid-CHASE with the debounce counter at 2.
    do_release("re_on", 2'd1, 4'b1111);
    do_release("re_blink", 2'd2, 4'b1111);
    do_release("re_chase", 2'd3, 4'b0001);
    sw = 1'b1;
    step(4);
    #2;
    rst_n = 1'b0;
    #1;
    check_all("async_rst", 2'd0, 1'b0, 4'b0000);
    sw = 1'b0;
    step(2);
    check_all("async_rst_hold", 2'd0, 1'b0, 4'b0000);
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      step(1);
      check_all("post_rst", 2'd0, 1'b0, 4'b0000);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
